// File: rtl/bf16_spi_pkg.sv
// Shared definitions for the bfloat16 coprocessor SPI link: word width,
// coprocessor opcodes, frame terminator and the host-master FSM encoding.
package bf16_spi_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] OP_ZERO     = 16'h0000;
  localparam logic [WORD_W-1:0] OP_SET_ACC  = 16'h0001;
  localparam logic [WORD_W-1:0] OP_LOAD_ACC = 16'h0002;
  localparam logic [WORD_W-1:0] OP_ADD      = 16'h0003;
  localparam logic [WORD_W-1:0] OP_SUB      = 16'h0004;
  localparam logic [WORD_W-1:0] OP_MUL      = 16'h0005;
  localparam logic [WORD_W-1:0] OP_DIV      = 16'h0006;
  localparam logic [WORD_W-1:0] OP_SUM      = 16'h0007;
  localparam logic [WORD_W-1:0] OP_SUBACC   = 16'h0008;

  localparam logic [WORD_W-1:0] WORD_END    = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/bf16_spi_shifter.sv
// Transmit/receive shift registers and bit counter for one SPI frame.
// Both directions move LSB-first: tx drains from bit 0, rx fills from the top.
module bf16_spi_shifter
  import bf16_spi_pkg::*;
#(
  parameter int WORD_W = bf16_spi_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              shift_en,
  input  logic              miso,
  output logic              mosi,
  output logic              last_bit,
  output logic [WORD_W-1:0] rx_word
);

  localparam int CNT_W = $clog2(WORD_W);

  logic [WORD_W-1:0] r_tx_sr;
  logic [WORD_W-1:0] r_rx_sr;
  logic [CNT_W-1:0]  r_bit_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would make the shift order-dependent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
      r_bit_cnt <= '0;
    end else if (load) begin
      r_tx_sr   <= load_data;
      r_rx_sr   <= '0;
      r_bit_cnt <= '0;
    end else if (shift_en) begin
      r_tx_sr   <= {1'b0, r_tx_sr[WORD_W-1:1]};
      r_rx_sr   <= {miso, r_rx_sr[WORD_W-1:1]};
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  assign mosi     = r_tx_sr[0];
  assign last_bit = (r_bit_cnt == CNT_W'(WORD_W - 1));
  assign rx_word  = r_rx_sr;

endmodule

// File: rtl/bf16_spi_host_master.sv
// Host-side SPI initiator for the bfloat16 coprocessor: frames one stream word
// per ss-low window, clocked by clk, and returns the captured miso word.
module bf16_spi_host_master
  import bf16_spi_pkg::*;
#(
  parameter int WORD_W    = bf16_spi_pkg::WORD_W,
  parameter int SETUP_CYC = 1,
  parameter int GAP_CYC   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              ss,
  output logic              mosi,
  input  logic              miso,
  output logic              busy
);

  localparam int CNT_W = 8;

  state_t            r_state;
  logic              r_ss;
  logic              r_out_valid;
  logic [WORD_W-1:0] r_out_data;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_shift_en;
  logic              w_tx_bit;
  logic              w_last_bit;
  logic [WORD_W-1:0] w_rx_word;

  // NOTE: in_ready is a pure function of registered state (plus rst), so a
  // continuous assign is enough and no latch or extra cycle of lag appears.
  assign in_ready   = (r_state == ST_IDLE) && !r_out_valid && !rst;
  assign w_accept   = in_valid && in_ready;
  assign w_shift_en = (r_state == ST_SHIFT);

  bf16_spi_shifter #(.WORD_W(WORD_W)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (w_accept),
    .load_data (in_data),
    .shift_en  (w_shift_en),
    .miso      (miso),
    .mosi      (w_tx_bit),
    .last_bit  (w_last_bit),
    .rx_word   (w_rx_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ss        <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_cnt       <= '0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_SETUP;
            r_ss    <= 1'b0;
            r_cnt   <= '0;
          end
        end
        ST_SETUP: begin
          if (r_cnt == CNT_W'(SETUP_CYC - 1)) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (w_last_bit) begin
            r_state <= ST_GAP;
            r_ss    <= 1'b1;
            r_cnt   <= '0;
          end
        end
        ST_GAP: begin
          // Response is only published once ss has been high for the full gap.
          if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
            r_state     <= ST_IDLE;
            r_out_data  <= w_rx_word;
            r_out_valid <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ss        = r_ss;
  assign mosi      = w_shift_en & w_tx_bit;
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_bf16_spi_host_master.sv
// Self-checking bench for bf16_spi_host_master: table-driven single frames,
// then hand-written back-to-back, backpressure, reset and parameter cases.
`timescale 1ns/1ps
module tb_bf16_spi_host_master;
  import bf16_spi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: default parameters
  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [15:0] a_in_data  = '0;
  logic        a_out_valid;
  logic        a_out_ready = 1'b0;
  logic [15:0] a_out_data;
  logic        a_ss, a_mosi, a_miso, a_busy;

  // DUT B: SETUP_CYC=3, GAP_CYC=1, loopback
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [15:0] b_in_data  = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [15:0] b_out_data;
  logic        b_ss, b_mosi, b_miso, b_busy;

  bf16_spi_host_master dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .ss(a_ss), .mosi(a_mosi), .miso(a_miso), .busy(a_busy)
  );

  bf16_spi_host_master #(.WORD_W(16), .SETUP_CYC(3), .GAP_CYC(1)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .ss(b_ss), .mosi(b_mosi), .miso(b_miso), .busy(b_busy)
  );

  assign b_miso = b_mosi;

  // Slave model for DUT A: after the one setup cycle, shift cycle k presents
  // slave_word[k]; outside the data bits miso idles high to expose stray sampling.
  logic        loop_mode  = 1'b1;
  logic [15:0] slave_word = '0;
  int          sl_cnt     = 0;
  logic [3:0]  sl_idx;
  always @(posedge clk) sl_cnt <= a_ss ? 0 : sl_cnt + 1;
  always_comb sl_idx = 4'(sl_cnt - 1);
  assign a_miso = loop_mode ? a_mosi :
                  ((sl_cnt >= 1 && sl_cnt <= 16) ? slave_word[sl_idx] : 1'b1);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic start_word(input logic [15:0] tx);
    int t;
    a_in_data  = tx;
    a_in_valid = 1'b1;
    t = 0;
    while (!a_in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("accept_wait_in_budget", 32'(t < 200), 32'd1);
    @(negedge clk);
    a_in_valid = 1'b0;
    a_in_data  = 16'hDEAD;
  endtask

  // Watches one frame until out_valid; lat counts the accepting edge as edge 1.
  task automatic watch_frame(input logic [15:0] tx, output int ss_low,
                             output int lat, output int mosi_bad);
    int n;
    logic [15:0] sh;
    sh = tx; ss_low = 0; mosi_bad = 0; n = 0;
    while (!a_out_valid && n < 200) begin
      if (!a_ss) begin
        if (ss_low == 0) begin
          if (a_mosi !== 1'b0) mosi_bad++;
        end else if (ss_low <= 16) begin
          if (a_mosi !== sh[0]) mosi_bad++;
          sh = sh >> 1;
        end
        ss_low++;
      end else if (a_mosi !== 1'b0) begin
        mosi_bad++;
      end
      @(negedge clk);
      n++;
    end
    lat = n + 1;
  endtask

  typedef struct {
    logic [15:0] tx;
    logic        loop;
    logic [15:0] slave;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs[6];
  logic [15:0] bb_tx[4];
  logic [15:0] bb_sl[4];
  logic [15:0] rsp[4];

  initial begin
    int ss_low, lat, bad, ngot, idx, hi_run, min_hi, n;
    logic started, acc;
    logic [15:0] held;

    vecs[0] = '{OP_SUB,   1'b1, 16'h0000, OP_SUB};
    vecs[1] = '{16'h4237, 1'b0, 16'hC411, 16'hC411};
    vecs[2] = '{WORD_END, 1'b1, 16'h0000, WORD_END};
    vecs[3] = '{16'h8001, 1'b0, 16'h7FFE, 16'h7FFE};
    vecs[4] = '{OP_ZERO,  1'b0, 16'hFFFF, 16'hFFFF};
    vecs[5] = '{16'hA5C3, 1'b1, 16'h0000, 16'hA5C3};

    bb_tx = '{OP_SUB, 16'h4237, 16'h441C, WORD_END};
    bb_sl = '{16'h3F80, 16'h4237, 16'h8001, 16'hC411};

    // Power-on reset, then a 5-cycle reset while idle.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_ss", a_ss, 1);
    check("rst_mosi", a_mosi, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_in_ready", a_in_ready, 0);
    check("rst_out_data", a_out_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", a_in_ready, 1);

    // Table of single frames.
    for (int i = 0; i < 6; i++) begin
      loop_mode  = vecs[i].loop;
      slave_word = vecs[i].slave;
      start_word(vecs[i].tx);
      watch_frame(vecs[i].tx, ss_low, lat, bad);
      check($sformatf("v%0d_out_data", i), a_out_data, vecs[i].exp);
      check($sformatf("v%0d_ss_low_cycles", i), ss_low, 17);
      check($sformatf("v%0d_latency_edges", i), lat, 20);
      check($sformatf("v%0d_mosi_bit_errors", i), bad, 0);
      a_out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_out_valid_cleared", i), a_out_valid, 0);
      check($sformatf("v%0d_in_ready_back", i), a_in_ready, 1);
      a_out_ready = 1'b0;
    end

    // Back-to-back stream with a varying slave response per frame.
    loop_mode   = 1'b0;
    slave_word  = bb_sl[0];
    a_out_ready = 1'b1;
    a_in_data   = bb_tx[0];
    a_in_valid  = 1'b1;
    idx = 0; ngot = 0; hi_run = 0; min_hi = 1000; started = 1'b0;
    for (int c = 0; c < 400 && ngot < 4; c++) begin
      if (!a_ss) begin
        if (started && hi_run > 0 && hi_run < min_hi) min_hi = hi_run;
        hi_run = 0;
        started = 1'b1;
      end else if (started) begin
        hi_run++;
      end
      if (a_out_valid) begin
        rsp[ngot] = a_out_data;
        ngot++;
        if (ngot < 4) slave_word = bb_sl[ngot];
      end
      acc = a_in_valid && a_in_ready;
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < 4) a_in_data = bb_tx[idx];
        else a_in_valid = 1'b0;
      end
    end
    check("b2b_responses", ngot, 4);
    for (int i = 0; i < 4; i++) check($sformatf("b2b_rsp%0d", i), rsp[i], bb_sl[i]);
    check("b2b_min_ss_high", min_hi, 4);
    check("b2b_all_accepted", a_in_valid, 0);

    // Backpressure: response held while a new word waits.
    a_out_ready = 1'b0;
    loop_mode   = 1'b1;
    start_word(OP_SUB);
    watch_frame(OP_SUB, ss_low, lat, bad);
    held = a_out_data;
    check("bp_first_rsp", held, OP_SUB);
    a_in_data  = 16'h4148;
    a_in_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_out_valid !== 1'b1 || a_out_data !== held || a_in_ready !== 1'b0 || a_ss !== 1'b1)
        bad++;
    end
    check("bp_stall_violations", bad, 0);
    a_out_ready = 1'b1;
    @(negedge clk);
    check("bp_out_valid_cleared", a_out_valid, 0);
    check("bp_in_ready_same_cycle", a_in_ready, 1);
    a_out_ready = 1'b0;
    @(negedge clk);
    check("bp_accepted_ss", a_ss, 0);
    check("bp_accepted_busy", a_busy, 1);
    a_in_valid = 1'b0;
    a_in_data  = 16'hDEAD;
    watch_frame(16'h4148, ss_low, lat, bad);
    check("bp_second_rsp", a_out_data, 16'h4148);
    check("bp_second_ss_low", ss_low, 17);
    check("bp_second_mosi", bad, 0);
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;

    // Reset mid-SHIFT at bit 7 of 0x404D.
    start_word(16'h404D);
    repeat (8) @(negedge clk);
    check("midrst_in_shift_ss", a_ss, 0);
    #2 rst = 1'b1;
    #1;
    check("midrst_ss_async", a_ss, 1);
    check("midrst_busy_async", a_busy, 0);
    check("midrst_mosi_async", a_mosi, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("midrst_no_out_valid", a_out_valid, 0);
    start_word(OP_LOAD_ACC);
    watch_frame(OP_LOAD_ACC, ss_low, lat, bad);
    check("midrst_next_ss_low", ss_low, 17);
    check("midrst_next_rsp", a_out_data, OP_LOAD_ACC);
    check("midrst_next_latency", lat, 20);
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;

    // Parameter variant: SETUP_CYC=3, GAP_CYC=1, loopback 0x3F80.
    b_in_data  = 16'h3F80;
    b_in_valid = 1'b1;
    n = 0;
    while (!b_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    b_in_data  = 16'h0000;
    n = 0; ss_low = 0;
    while (!b_out_valid && n < 200) begin
      if (!b_ss) ss_low++;
      @(negedge clk);
      n++;
    end
    check("p_ss_low", ss_low, 19);
    check("p_rsp", b_out_data, 16'h3F80);
    check("p_latency", n + 1, 21);
    b_out_ready = 1'b1;
    @(negedge clk);
    check("p_out_valid_cleared", b_out_valid, 0);
    b_out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bf16_spi_host_master.md
Name: bf16_spi_host_master

Overview:
Host-side SPI initiator that drives the bfloat16 coprocessor slave (bfloat16_spi_top) over its ss/mosi/miso link.
- Accepts 16-bit command/operand words on a valid/ready stream and frames each one with ss low.
- Shifts each word out LSB-first on mosi, one bit per clk, while capturing miso into a 16-bit response word.
- The response is returned on a valid/ready stream.
- The SPI bit clock is the shared system clk; the block generates no separate serial clock.

Parameters:
WORD_W, 16, bits per SPI frame
SETUP_CYC, 1, cycles ss is held low before the first data bit (min 1)
GAP_CYC, 2, cycles ss is held high after the last bit before the response is presented (min 1)

Ports:
clk  in  1  system clock, also the SPI bit clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  word available to transmit
in_ready  out  1  block can accept a word
in_data  in  WORD_W  word to transmit (opcode, operand, or 0xFFFF dummy/terminator)
out_valid  out  1  captured miso word available
out_ready  in  1  consumer takes the response
out_data  out  WORD_W  word captured from miso, LSB first
ss  out  1  slave select, active low
mosi  out  1  serial data to slave
miso  in  1  serial data from slave
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values (asynchronous, while rst=1):
  - ss=1, mosi=0, out_valid=0, out_data=0, busy=0, in_ready=0.
  - State returns to IDLE immediately, including mid-frame: ss rises at once and the partial word is discarded.
- in_ready = (state==IDLE) && !out_valid && !rst. At most one word is in flight.
- FSM states and transitions:
  - IDLE: on in_valid && in_ready at edge E0, latch in_data into tx_sr, clear rx_sr and bit_cnt, go SETUP. From E0+1: ss=0, busy=1.
  - SETUP: hold for SETUP_CYC cycles with ss=0, mosi=0, then go SHIFT.
  - SHIFT: exactly WORD_W cycles. During shift cycle k (k=0..15), mosi=tx_sr[k].
    - At the edge ending cycle k, rx_sr[k] <= miso and bit_cnt increments.
    - When bit_cnt reaches WORD_W-1, the next state is GAP.
  - GAP: ss=1, mosi=0 for GAP_CYC cycles. At the edge ending GAP, out_data <= rx_sr, out_valid <= 1, go IDLE.
- Frame length: ss is low for exactly SETUP_CYC+WORD_W cycles (17 at defaults).
- Latency: out_valid rises SETUP_CYC+WORD_W+GAP_CYC+1 edges after acceptance (20 at defaults).
- Output handshake:
  - out_valid/out_data hold stable until out_valid && out_ready.
  - out_valid clears on the edge of that transfer.
  - in_ready rises in the same cycle out_valid falls (combinational from registered state).
- Back-to-back throughput: with in_valid held high and out_ready held high, the next acceptance occurs 1 cycle after the response transfer. Minimum ss-high between frames is GAP_CYC+2 cycles.
- Pipeline stalls: out_ready low indefinitely stalls new transmissions. No word is ever dropped or overwritten.
- mosi is never driven with data bits while ss=1.
- miso is ignored outside SHIFT.
- in_data changes after acceptance have no effect on the current frame.

Decomposition:
- Shared package bf16_spi_pkg contains:
  - WORD_W.
  - Opcode constants: OP_ZERO=0x0000, OP_SET_ACC=0x0001, OP_LOAD_ACC=0x0002, OP_ADD=0x0003, OP_SUB=0x0004, OP_MUL=0x0005, OP_DIV=0x0006, OP_SUM=0x0007, OP_SUBACC=0x0008.
  - WORD_END=0xFFFF.
  - FSM state encoding (IDLE, SETUP, SHIFT, GAP).
- One natural sub-module: bf16_spi_shifter.
  - Holds the tx/rx 16-bit shift registers and the bit counter.
  - Inputs: load, shift_en, miso. Outputs: mosi, last_bit, rx_word.
- The FSM and handshakes stay in the top.

Test Plan:
- Reset: assert rst for 5 cycles mid-idle → ss=1, mosi=0, out_valid=0, busy=0. Release → in_ready=1 the next cycle.
- Single word 0x0004, miso tied to mosi (loopback) → ss low exactly 17 cycles, mosi bit sequence 0,0,1,0,0×12 after 1 setup cycle, out_data=0x0004, out_valid 20 edges after acceptance.
- Slave model returns 0xC411 LSB-first; send 0x0004,0x4237,0x441C,0xFFFF back-to-back with out_ready=1 → four responses in order, last out_data=0xC411, ss-high ≥ GAP_CYC+2 between frames.
- Backpressure: out_ready=0 after first response, in_valid=1 with 0x4148 → out_valid/out_data stay constant, in_ready=0, ss stays 1. Raise out_ready → transfer, then 0x4148 accepted next cycle.
- Reset mid-SHIFT at bit 7 of 0x404D → ss rises asynchronously, no out_valid. After release, sending 0x0002 yields a clean 17-cycle frame.
- Parameter sweep SETUP_CYC=3, GAP_CYC=1 with 0x3F80 loopback → ss low 19 cycles, out_data=0x3F80, latency 21 edges.
